// File: rtl/tx_packet_dispatcher_pkg.sv
// Shared definitions for the TX packet dispatcher: FSM encodings, header
// field layout, special channel/timestamp values and drop-reason codes.
package tx_packet_dispatcher_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HDR0      = 4'd1,
        ST_HDR1      = 4'd2,
        ST_TS0       = 4'd3,
        ST_TS1       = 4'd4,
        ST_WAIT_TIME = 4'd5,
        ST_CMD_WAIT  = 4'd6,
        ST_PAYLOAD   = 4'd7,
        ST_DROP      = 4'd8,
        ST_DRAIN     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        DROP_NONE     = 2'd0,
        DROP_LATE     = 2'd1,
        DROP_BAD_LEN  = 2'd2,
        DROP_BAD_CHAN = 2'd3
    } drop_reason_t;

    // Header word 0: {start, end, rsvd[4:0], len[8:0]}
    localparam int HDR_START_BIT = 15;
    localparam int HDR_END_BIT   = 14;
    localparam int HDR_LEN_W     = 9;
    // Header word 1: {rsvd[10:0], chan[4:0]}
    localparam int HDR_CHAN_W    = 5;

    localparam int          HDR_WORDS = 4;
    localparam logic [4:0]  CMD_CHAN  = 5'h1F;
    localparam logic [31:0] TS_NOW    = 32'hFFFF_FFFF;

endpackage

// File: rtl/tx_time_gate.sv
// Wrap-safe comparison of a packet timestamp against the sample-time counter.
// The difference is interpreted as a signed 32-bit value so the counter may
// wrap between the packet being queued and its scheduled time.
module tx_time_gate (
    input  logic [31:0] i_timestamp,
    input  logic [31:0] i_adctime,
    output logic        o_go,
    output logic        o_late,
    output logic        o_wait
);

    logic signed [31:0] w_diff;

    assign w_diff = $signed(i_timestamp - i_adctime);
    assign o_go   = (w_diff == 32'sd0);
    assign o_late = (w_diff < 32'sd0);
    assign o_wait = !o_go && !o_late;

endmodule

// File: rtl/tx_packet_dispatcher.sv
// TX packet dispatcher: pops fixed-size USB packets, parses the 4-word header,
// schedules sample packets against adctime and routes payload words to the
// per-channel sample FIFOs or to the command path. Late/malformed packets are
// drained without forwarding.
// Optional feature macro: TX_DROP_STATS_EN (drop_count/drop_reason outputs,
// start bit shown on debugbus[15]). The end bit of the header is not used.
module tx_packet_dispatcher
    import tx_packet_dispatcher_pkg::*;
#(
    parameter int NUM_CHAN  = 2,
    parameter int PKT_WORDS = 256
) (
    input  logic                txclk,
    input  logic                reset_n,
    input  logic [15:0]         usb_q,
    input  logic                usb_empty,
    input  logic                usb_pkt_rdy,
    output logic                usb_rdreq,
    input  logic [31:0]         adctime,
    input  logic [NUM_CHAN-1:0] chan_full,
    output logic [NUM_CHAN-1:0] chan_wrreq,
    output logic [15:0]         chan_data,
    input  logic                cmd_WR_enabled,
    output logic                cmd_WR,
    output logic [15:0]         cmd_databus,
    output logic                cmd_WR_done,
    input  logic                clear_status,
    output logic                tx_late,
    output logic                dropped,
`ifdef TX_DROP_STATS_EN
    output logic [15:0]         debugbus,
    output logic [15:0]         drop_count,
    output logic [1:0]          drop_reason
`else
    output logic [15:0]         debugbus
`endif
);

    localparam logic [8:0] PKT_WORDS_W = 9'(PKT_WORDS);
    localparam logic [8:0] MAX_LEN     = 9'(PKT_WORDS - HDR_WORDS);
    localparam logic [4:0] NUM_CHAN_W  = 5'(NUM_CHAN);

    state_t              r_state;
    state_t              w_state_next;
    logic [8:0]          r_word_cnt;
    logic [8:0]          r_pay_cnt;
    logic [8:0]          r_len;
    logic [4:0]          r_chan;
    logic [31:0]         r_ts;

    logic                w_pop;
    logic                w_pay_pop;
    logic                w_pay_done;
    logic                w_late_now;
    logic                w_len_bad;
    logic                w_chan_bad;
    logic                w_is_cmd;
    logic                w_dest_full;
    logic                w_gate_go;
    logic                w_gate_late;
    logic                w_gate_wait;
    logic [NUM_CHAN-1:0] w_chan_sel;
    logic [NUM_CHAN-1:0] w_full_hit;

    logic [NUM_CHAN-1:0] r_chan_wrreq;
    logic [15:0]         r_chan_data;
    logic                r_cmd_WR;
    logic [15:0]         r_cmd_databus;
    logic                r_cmd_done;
    logic                r_dropped;
    logic                r_tx_late;

    // Channel decode; the command channel matches no sample FIFO, so it never
    // sees backpressure from chan_full.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            assign w_chan_sel[gi] = (r_chan == 5'(gi));
            assign w_full_hit[gi] = w_chan_sel[gi] & chan_full[gi];
        end
    endgenerate

    assign w_dest_full = |w_full_hit;
    assign w_is_cmd    = (r_chan == CMD_CHAN);
    assign w_len_bad   = (r_len > MAX_LEN);
    assign w_chan_bad  = (r_chan >= NUM_CHAN_W) && !w_is_cmd;
    assign w_pay_pop   = w_pop && (r_state == ST_PAYLOAD);

    tx_time_gate u_time_gate (
        .i_timestamp (r_ts),
        .i_adctime   (adctime),
        .o_go        (w_gate_go),
        .o_late      (w_gate_late),
        .o_wait      (w_gate_wait)
    );

    // State register.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state and pop decision. The TS1 routing decision uses the live
    // timestamp-high word so no extra decode cycle is needed.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_pay_done   = 1'b0;
        w_late_now   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (usb_pkt_rdy) w_state_next = ST_HDR0;
            end
            ST_HDR0: begin
                if (!usb_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (!usb_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_TS0;
                end
            end
            ST_TS0: begin
                if (!usb_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_TS1;
                end
            end
            ST_TS1: begin
                if (!usb_empty) begin
                    w_pop = 1'b1;
                    if (w_len_bad || w_chan_bad)               w_state_next = ST_DROP;
                    else if (w_is_cmd)                         w_state_next = ST_CMD_WAIT;
                    else if ({usb_q, r_ts[15:0]} == TS_NOW)    w_state_next = ST_PAYLOAD;
                    else                                       w_state_next = ST_WAIT_TIME;
                end
            end
            ST_WAIT_TIME: begin
                if (w_gate_wait) begin
                    w_state_next = ST_WAIT_TIME;
                end else if (w_gate_go) begin
                    w_state_next = ST_PAYLOAD;
                end else if (w_gate_late) begin
                    w_state_next = ST_DROP;
                    w_late_now   = 1'b1;
                end
            end
            ST_CMD_WAIT: begin
                if (cmd_WR_enabled) w_state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (r_pay_cnt == r_len) begin
                    w_state_next = ST_DRAIN;
                    w_pay_done   = 1'b1;
                end else if (!usb_empty && !w_dest_full) begin
                    w_pop = 1'b1;
                end
            end
            ST_DROP: begin
                w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_word_cnt == PKT_WORDS_W) w_state_next = ST_IDLE;
                else if (!usb_empty)           w_pop = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Header field capture as each header word is popped.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_len  <= '0;
            r_chan <= '0;
            r_ts   <= '0;
        end else if (w_pop) begin
            case (r_state)
                ST_HDR0: r_len        <= usb_q[HDR_LEN_W-1:0];
                ST_HDR1: r_chan       <= usb_q[HDR_CHAN_W-1:0];
                ST_TS0:  r_ts[15:0]   <= usb_q;
                ST_TS1:  r_ts[31:16]  <= usb_q;
                default: ;
            endcase
        end
    end

    // Packet word counter and payload word counter.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
            r_pay_cnt  <= '0;
        end else begin
            if (r_state == ST_DRAIN && w_state_next == ST_IDLE) r_word_cnt <= '0;
            else if (w_pop)                                      r_word_cnt <= r_word_cnt + 9'd1;
            if (r_state == ST_TS1)  r_pay_cnt <= '0;
            else if (w_pay_pop)     r_pay_cnt <= r_pay_cnt + 9'd1;
        end
    end

    // Registered payload presentation, done/drop pulses and sticky late flag.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_chan_wrreq  <= '0;
            r_chan_data   <= '0;
            r_cmd_WR      <= 1'b0;
            r_cmd_databus <= '0;
            r_cmd_done    <= 1'b0;
            r_dropped     <= 1'b0;
            r_tx_late     <= 1'b0;
        end else begin
            r_chan_wrreq <= (w_pay_pop && !w_is_cmd) ? w_chan_sel : '0;
            if (w_pay_pop && !w_is_cmd) r_chan_data <= usb_q;
            r_cmd_WR <= w_pay_pop && w_is_cmd;
            if (w_pay_pop && w_is_cmd) r_cmd_databus <= usb_q;
            r_cmd_done <= w_pay_done && w_is_cmd;
            r_dropped  <= (r_state == ST_DROP);
            if (w_late_now)        r_tx_late <= 1'b1;
            else if (clear_status) r_tx_late <= 1'b0;
        end
    end

    assign usb_rdreq   = w_pop;
    assign chan_wrreq  = r_chan_wrreq;
    assign chan_data   = r_chan_data;
    assign cmd_WR      = r_cmd_WR;
    assign cmd_databus = r_cmd_databus;
    assign cmd_WR_done = r_cmd_done;
    assign dropped     = r_dropped;
    assign tx_late     = r_tx_late;

`ifdef TX_DROP_STATS_EN
    logic         r_start;
    drop_reason_t r_drop_cause;
    logic [15:0]  r_drop_count;
    drop_reason_t r_drop_reason;

    // Start bit capture for debug visibility.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n)                           r_start <= 1'b0;
        else if (w_pop && r_state == ST_HDR0)   r_start <= usb_q[HDR_START_BIT];
    end

    // Remember why the pending drop happens; bad length takes precedence.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n)                          r_drop_cause <= DROP_NONE;
        else if (w_pop && r_state == ST_TS1)   r_drop_cause <= w_len_bad ? DROP_BAD_LEN : DROP_BAD_CHAN;
        else if (w_late_now)                   r_drop_cause <= DROP_LATE;
    end

    // Saturating drop counter and last reason; a new drop beats clear_status.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count  <= '0;
            r_drop_reason <= DROP_NONE;
        end else if (r_state == ST_DROP) begin
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            r_drop_reason <= r_drop_cause;
        end else if (clear_status) begin
            r_drop_count  <= '0;
            r_drop_reason <= DROP_NONE;
        end
    end

    assign drop_count  = r_drop_count;
    assign drop_reason = r_drop_reason;
    assign debugbus    = {r_start, r_state[2:0], r_chan, r_word_cnt[6:0]};
`else
    assign debugbus    = {r_state, r_chan, r_word_cnt[6:0]};
`endif

endmodule

// File: tb/tb_tx_packet_dispatcher.sv
// Directed self-checking bench for tx_packet_dispatcher. The bench models the
// show-ahead USB FIFO and the adctime counter, logs every DUT output event at
// the falling edge and checks the logs against hand-computed expectations.
`timescale 1ns/1ps
module tb_tx_packet_dispatcher;

    localparam int NUM_CHAN  = 2;
    localparam int PKT_WORDS = 256;

    logic                txclk = 1'b0;
    logic                reset_n = 1'b1;
    logic [15:0]         usb_q = 16'h0;
    logic                usb_empty = 1'b1;
    logic                usb_pkt_rdy = 1'b0;
    logic                usb_rdreq;
    logic [31:0]         adctime = 32'h0000_1000;
    logic [NUM_CHAN-1:0] chan_full = '0;
    logic [NUM_CHAN-1:0] chan_wrreq;
    logic [15:0]         chan_data;
    logic                cmd_WR_enabled = 1'b1;
    logic                cmd_WR;
    logic [15:0]         cmd_databus;
    logic                cmd_WR_done;
    logic                clear_status = 1'b0;
    logic                tx_late;
    logic                dropped;
    logic [15:0]         debugbus;
`ifdef TX_DROP_STATS_EN
    logic [15:0]         drop_count;
    logic [1:0]          drop_reason;
`endif

    tx_packet_dispatcher #(.NUM_CHAN(NUM_CHAN), .PKT_WORDS(PKT_WORDS)) dut (
        .txclk          (txclk),
        .reset_n        (reset_n),
        .usb_q          (usb_q),
        .usb_empty      (usb_empty),
        .usb_pkt_rdy    (usb_pkt_rdy),
        .usb_rdreq      (usb_rdreq),
        .adctime        (adctime),
        .chan_full      (chan_full),
        .chan_wrreq     (chan_wrreq),
        .chan_data      (chan_data),
        .cmd_WR_enabled (cmd_WR_enabled),
        .cmd_WR         (cmd_WR),
        .cmd_databus    (cmd_databus),
        .cmd_WR_done    (cmd_WR_done),
        .clear_status   (clear_status),
        .tx_late        (tx_late),
        .dropped        (dropped),
`ifdef TX_DROP_STATS_EN
        .debugbus       (debugbus),
        .drop_count     (drop_count),
        .drop_reason    (drop_reason)
`else
        .debugbus       (debugbus)
`endif
    );

    always #5 txclk = ~txclk;

    // USB FIFO model and event logs
    logic [15:0]         fifo_q[$];
    logic                pop_armed = 1'b0;
    int                  cyc = 0;
    int                  pop_cnt = 0;
    int                  drop_cnt = 0;
    logic [15:0]         wr_data_q[$];
    logic [NUM_CHAN-1:0] wr_chan_q[$];
    logic [31:0]         wr_adc_q[$];
    logic [15:0]         cmd_q[$];
    int                  cmd_cyc_q[$];
    int                  done_cyc_q[$];
    bit                  bp_en = 1'b0;
    logic [31:0]         adc_load_val = '0;
    int                  adc_load_seq = 0;
    int                  adc_seen_seq = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO pop / adctime / backpressure updates, all 1 ns after the edge.
    always @(posedge txclk) begin
        if (pop_armed && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        if (adc_load_seq != adc_seen_seq) begin
            adctime      = adc_load_val;
            adc_seen_seq = adc_load_seq;
        end else begin
            adctime = adctime + 32'd1;
        end
        chan_full   = (bp_en && (cyc % 3 == 0)) ? 2'b01 : 2'b00;
        usb_empty   = (fifo_q.size() == 0);
        usb_q       = usb_empty ? 16'h0 : fifo_q[0];
        usb_pkt_rdy = (fifo_q.size() >= PKT_WORDS);
    end

    // Output monitor on the falling edge.
    always @(negedge txclk) begin
        cyc = cyc + 1;
        pop_armed = usb_rdreq && !usb_empty;
        if (usb_rdreq) pop_cnt = pop_cnt + 1;
        if (chan_wrreq != '0) begin
            wr_data_q.push_back(chan_data);
            wr_chan_q.push_back(chan_wrreq);
            wr_adc_q.push_back(adctime);
        end
        if (cmd_WR) begin
            cmd_q.push_back(cmd_databus);
            cmd_cyc_q.push_back(cyc);
        end
        if (cmd_WR_done) done_cyc_q.push_back(cyc);
        if (dropped) drop_cnt = drop_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge txclk);
        #2;
    endtask

    task automatic push_pkt(input logic [8:0] len, input logic [4:0] chan,
                            input logic [31:0] ts, input logic [15:0] base);
        int n;
        fifo_q.push_back({1'b1, 1'b1, 5'b0, len});
        fifo_q.push_back({11'b0, chan});
        fifo_q.push_back(ts[15:0]);
        fifo_q.push_back(ts[31:16]);
        n = (int'(len) > PKT_WORDS - 4) ? PKT_WORDS - 4 : int'(len);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
        while (fifo_q.size() % PKT_WORDS != 0) fifo_q.push_back(16'hEEEE);
    endtask

    task automatic wait_pkts_done(input string name);
        int k;
        k = 0;
        while (fifo_q.size() != 0 && k < 4000) begin
            @(negedge txclk);
            k++;
        end
        repeat (3) @(negedge txclk);
        n_checks++;
        if (fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: fifo words left %0d, expected 0", name, fifo_q.size());
        end
        n_checks++;
        if (debugbus[14:12] !== 3'b000 || debugbus[6:0] !== 7'd0) begin
            n_fail++;
            $display("FAIL %s_idle: debugbus %h, expected state IDLE and word_cnt 0", name, debugbus);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge txclk);
        n_checks++;
        if ({usb_rdreq, chan_wrreq, cmd_WR, cmd_WR_done, tx_late, dropped} !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, expected 0",
                     {usb_rdreq, chan_wrreq, cmd_WR, cmd_WR_done, tx_late, dropped});
        end
        n_checks++;
        if (chan_data !== 16'h0 || cmd_databus !== 16'h0 || debugbus !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_buses: chan_data %h cmd_databus %h debugbus %h, expected 0",
                     chan_data, cmd_databus, debugbus);
        end
`ifdef TX_DROP_STATS_EN
        n_checks++;
        if (drop_count !== 16'h0 || drop_reason !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_stats: count %0d reason %0d, expected 0 0", drop_count, drop_reason);
        end
`endif
        sync();
        reset_n = 1'b1;
        @(negedge txclk);
        n_checks++;
        if (debugbus !== 16'h0 || usb_rdreq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: debugbus %h rdreq %b, expected 0 0", debugbus, usb_rdreq);
        end
    endtask

    task automatic test_immediate();
        int bw, bp, bd;
        sync();
        bw = wr_data_q.size(); bp = pop_cnt; bd = drop_cnt;
        push_pkt(9'd10, 5'd1, 32'hFFFF_FFFF, 16'd0);
        wait_pkts_done("immediate");
        n_checks++;
        if (wr_data_q.size() - bw != 10) begin
            n_fail++;
            $display("FAIL immediate_count: got %0d writes, expected 10", wr_data_q.size() - bw);
        end
        for (int i = 0; i < 10 && bw + i < wr_data_q.size(); i++) begin
            n_checks++;
            if (wr_data_q[bw+i] !== 16'(i) || wr_chan_q[bw+i] !== 2'b10) begin
                n_fail++;
                $display("FAIL immediate_word%0d: got %h on %b, expected %h on 10",
                         i, wr_data_q[bw+i], wr_chan_q[bw+i], i);
            end
        end
        n_checks++;
        if (pop_cnt - bp != 256 || drop_cnt - bd != 0) begin
            n_fail++;
            $display("FAIL immediate_pops: got %0d pops %0d drops, expected 256 0",
                     pop_cnt - bp, drop_cnt - bd);
        end
        $display("immediate packet: %0d writes, %0d pops", wr_data_q.size() - bw, pop_cnt - bp);
    endtask

    // The time gate matches at the edge where adctime == ts, the word is
    // popped the following cycle and registered one cycle later, so the
    // first write is logged while adctime reads ts + 2.
    task automatic test_timed(input string name, input logic [31:0] start_adc,
                              input bit load_adc, input logic [31:0] ts_in, input bit rel);
        int bw, bd;
        logic [31:0] ts;
        sync();
        if (load_adc) begin
            adc_load_val = start_adc;
            adc_load_seq++;
            sync();
        end
        ts = rel ? adctime + ts_in : ts_in;
        bw = wr_data_q.size(); bd = drop_cnt;
        push_pkt(9'd4, 5'd0, ts, 16'hA000);
        wait_pkts_done(name);
        n_checks++;
        if (wr_data_q.size() - bw != 4) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, expected 4", name, wr_data_q.size() - bw);
        end else begin
            n_checks++;
            if (wr_adc_q[bw] !== ts + 32'd2) begin
                n_fail++;
                $display("FAIL %s_latency: first write at adctime %h, expected %h",
                         name, wr_adc_q[bw], ts + 32'd2);
            end
        end
        n_checks++;
        if (drop_cnt - bd != 0 || tx_late !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_nodrop: got %0d drops tx_late %b, expected 0 0",
                     name, drop_cnt - bd, tx_late);
        end
        $display("%s packet: ts %h, first write adctime %h", name, ts,
                 (wr_data_q.size() > bw) ? wr_adc_q[bw] : 32'h0);
    endtask

    task automatic test_late();
        int bw, bp, bd;
        sync();
        bw = wr_data_q.size(); bp = pop_cnt; bd = drop_cnt;
        push_pkt(9'd4, 5'd0, adctime - 32'd1, 16'hB000);
        wait_pkts_done("late");
        n_checks++;
        if (drop_cnt - bd != 1 || wr_data_q.size() - bw != 0) begin
            n_fail++;
            $display("FAIL late_drop: got %0d drops %0d writes, expected 1 0",
                     drop_cnt - bd, wr_data_q.size() - bw);
        end
        n_checks++;
        if (pop_cnt - bp != 256 || tx_late !== 1'b1) begin
            n_fail++;
            $display("FAIL late_flag: got %0d pops tx_late %b, expected 256 1", pop_cnt - bp, tx_late);
        end
`ifdef TX_DROP_STATS_EN
        n_checks++;
        if (drop_reason !== 2'd1) begin
            n_fail++;
            $display("FAIL late_reason: got %0d, expected 1", drop_reason);
        end
`endif
        sync();
        clear_status = 1'b1;
        sync();
        clear_status = 1'b0;
        @(negedge txclk);
        n_checks++;
        if (tx_late !== 1'b0) begin
            n_fail++;
            $display("FAIL late_clear: tx_late %b, expected 0", tx_late);
        end
        $display("late packet: %0d drops, %0d pops", drop_cnt - bd, pop_cnt - bp);
    endtask

    task automatic test_backpressure();
        int bw, bp, bad;
        sync();
        bw = wr_data_q.size(); bp = pop_cnt;
        bp_en = 1'b1;
        push_pkt(9'd252, 5'd0, 32'hFFFF_FFFF, 16'h1000);
        wait_pkts_done("backpressure");
        bp_en = 1'b0;
        n_checks++;
        if (wr_data_q.size() - bw != 252) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes, expected 252", wr_data_q.size() - bw);
        end
        bad = 0;
        for (int i = 0; i < 252 && bw + i < wr_data_q.size(); i++) begin
            if (wr_data_q[bw+i] !== 16'h1000 + 16'(i) || wr_chan_q[bw+i] !== 2'b01) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_order: %0d words out of order or misrouted, expected 0", bad);
        end
        n_checks++;
        if (pop_cnt - bp != 256) begin
            n_fail++;
            $display("FAIL bp_pops: got %0d, expected 256", pop_cnt - bp);
        end
        $display("backpressure packet: %0d writes, %0d bad", wr_data_q.size() - bw, bad);
    endtask

    task automatic test_command();
        int bc, bd, bw, bp;
        sync();
        cmd_WR_enabled = 1'b0;
        bc = cmd_q.size(); bd = done_cyc_q.size(); bw = wr_data_q.size(); bp = pop_cnt;
        push_pkt(9'd3, 5'h1F, 32'h0000_0001, 16'hC000);
        repeat (20) @(posedge txclk);
        @(negedge txclk);
        n_checks++;
        if (cmd_q.size() - bc != 0 || pop_cnt - bp != 4) begin
            n_fail++;
            $display("FAIL cmd_hold: got %0d strobes %0d pops, expected 0 4",
                     cmd_q.size() - bc, pop_cnt - bp);
        end
        sync();
        cmd_WR_enabled = 1'b1;
        wait_pkts_done("command");
        n_checks++;
        if (cmd_q.size() - bc != 3 || wr_data_q.size() - bw != 0) begin
            n_fail++;
            $display("FAIL cmd_count: got %0d strobes %0d chan writes, expected 3 0",
                     cmd_q.size() - bc, wr_data_q.size() - bw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cmd_q[bc+i] !== 16'hC000 + 16'(i)) begin
                    n_fail++;
                    $display("FAIL cmd_word%0d: got %h, expected %h", i, cmd_q[bc+i], 16'hC000 + 16'(i));
                end
            end
            n_checks++;
            if (done_cyc_q.size() - bd != 1) begin
                n_fail++;
                $display("FAIL cmd_done_count: got %0d, expected 1", done_cyc_q.size() - bd);
            end else begin
                n_checks++;
                if (done_cyc_q[bd] != cmd_cyc_q[bc+2] + 1) begin
                    n_fail++;
                    $display("FAIL cmd_done_cycle: got %0d, expected %0d", done_cyc_q[bd], cmd_cyc_q[bc+2] + 1);
                end
            end
        end
        $display("command packet: %0d strobes, %0d done pulses", cmd_q.size() - bc, done_cyc_q.size() - bd);
        // empty command packet: no strobes but still one done pulse
        sync();
        bc = cmd_q.size(); bd = done_cyc_q.size();
        push_pkt(9'd0, 5'h1F, 32'h0, 16'h0);
        wait_pkts_done("cmd_len0");
        n_checks++;
        if (cmd_q.size() - bc != 0 || done_cyc_q.size() - bd != 1) begin
            n_fail++;
            $display("FAIL cmd_len0: got %0d strobes %0d done, expected 0 1",
                     cmd_q.size() - bc, done_cyc_q.size() - bd);
        end
        $display("empty command packet: %0d done pulses", done_cyc_q.size() - bd);
    endtask

    task automatic test_bad_header();
        int bw, bp, bd;
        sync();
        clear_status = 1'b1;
        sync();
        clear_status = 1'b0;
        bw = wr_data_q.size(); bp = pop_cnt; bd = drop_cnt;
        push_pkt(9'd300, 5'd0, 32'hFFFF_FFFF, 16'hD000);
        wait_pkts_done("bad_len");
        n_checks++;
        if (drop_cnt - bd != 1 || wr_data_q.size() - bw != 0 || pop_cnt - bp != 256) begin
            n_fail++;
            $display("FAIL bad_len: got %0d drops %0d writes %0d pops, expected 1 0 256",
                     drop_cnt - bd, wr_data_q.size() - bw, pop_cnt - bp);
        end
`ifdef TX_DROP_STATS_EN
        n_checks++;
        if (drop_reason !== 2'd2 || drop_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bad_len_stats: reason %0d count %0d, expected 2 1", drop_reason, drop_count);
        end
`endif
        sync();
        bw = wr_data_q.size(); bd = drop_cnt;
        push_pkt(9'd4, 5'd3, 32'hFFFF_FFFF, 16'hD100);
        wait_pkts_done("bad_chan");
        n_checks++;
        if (drop_cnt - bd != 1 || wr_data_q.size() - bw != 0 || tx_late !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chan: got %0d drops %0d writes tx_late %b, expected 1 0 0",
                     drop_cnt - bd, wr_data_q.size() - bw, tx_late);
        end
`ifdef TX_DROP_STATS_EN
        n_checks++;
        if (drop_reason !== 2'd3 || drop_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bad_chan_stats: reason %0d count %0d, expected 3 2", drop_reason, drop_count);
        end
`endif
        $display("bad header packets: %0d drops", drop_cnt - bd + 1);
    endtask

    task automatic test_back_to_back();
        int bw, bp;
        logic [15:0]         exp_d[5];
        logic [NUM_CHAN-1:0] exp_c[5];
        exp_d = '{16'h2000, 16'h2001, 16'h3000, 16'h3001, 16'h3002};
        exp_c = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        sync();
        bw = wr_data_q.size(); bp = pop_cnt;
        push_pkt(9'd2, 5'd0, 32'hFFFF_FFFF, 16'h2000);
        push_pkt(9'd3, 5'd1, 32'hFFFF_FFFF, 16'h3000);
        wait_pkts_done("back_to_back");
        n_checks++;
        if (wr_data_q.size() - bw != 5 || pop_cnt - bp != 512) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes %0d pops, expected 5 512",
                     wr_data_q.size() - bw, pop_cnt - bp);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr_data_q[bw+i] !== exp_d[i] || wr_chan_q[bw+i] !== exp_c[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: got %h on %b, expected %h on %b",
                             i, wr_data_q[bw+i], wr_chan_q[bw+i], exp_d[i], exp_c[i]);
                end
            end
        end
        $display("back-to-back packets: %0d writes, %0d pops", wr_data_q.size() - bw, pop_cnt - bp);
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_timed("timed", 32'h0, 1'b0, 32'd50, 1'b1);
        test_timed("wrap", 32'hFFFF_FFF0, 1'b1, 32'h0000_0005, 1'b0);
        test_late();
        test_backpressure();
        test_command();
        test_bad_header();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
